// File: rtl/vadd_pkg.sv
// Shared definitions for the pipelined vector add/subtract unit.
//   - opSel operation codes and sew element-width codes
//   - op_class_t: the decoded operation class that travels down the pipeline
//   - decode_op():  opSel -> op_class_t
//   - lane_mask():  sew -> low byte-index bits that select a byte within an element
package vadd_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_RSUB  = 4'd2;
  localparam logic [3:0] OP_ADC   = 4'd3;
  localparam logic [3:0] OP_SBC   = 4'd4;
  localparam logic [3:0] OP_MADC  = 4'd5;
  localparam logic [3:0] OP_MSBC  = 4'd6;
  localparam logic [3:0] OP_SADDU = 4'd7;
  localparam logic [3:0] OP_SADD  = 4'd8;
  localparam logic [3:0] OP_SSUBU = 4'd9;
  localparam logic [3:0] OP_SSUB  = 4'd10;

  localparam logic [1:0] SEW_8  = 2'd0;
  localparam logic [1:0] SEW_16 = 2'd1;
  localparam logic [1:0] SEW_32 = 2'd2;
  localparam logic [1:0] SEW_64 = 2'd3;

  // is_nop marks reserved codes: they flow through the pipe but produce all zeros.
  typedef struct packed {
    logic is_nop;
    logic is_sub;
    logic is_rev;
    logic use_cin;
    logic is_sat;
    logic is_signed;
  } op_class_t;

  function automatic op_class_t decode_op(input logic [3:0] op);
    op_class_t c;
    c = '0;
    case (op)
      OP_ADD:           c = '0;
      OP_SUB:           c.is_sub = 1'b1;
      OP_RSUB:          begin c.is_sub = 1'b1; c.is_rev = 1'b1; end
      OP_ADC, OP_MADC:  c.use_cin = 1'b1;
      OP_SBC, OP_MSBC:  begin c.is_sub = 1'b1; c.use_cin = 1'b1; end
      OP_SADDU:         c.is_sat = 1'b1;
      OP_SADD:          begin c.is_sat = 1'b1; c.is_signed = 1'b1; end
      OP_SSUBU:         begin c.is_sub = 1'b1; c.is_sat = 1'b1; end
      OP_SSUB:          begin c.is_sub = 1'b1; c.is_sat = 1'b1; c.is_signed = 1'b1; end
      default:          c.is_nop = 1'b1;
    endcase
    return c;
  endfunction

  // Elements are 1/2/4/8 bytes, so a byte is the first of its element when
  // (byte_index & mask) == 0 and the last when (byte_index & mask) == mask.
  function automatic logic [2:0] lane_mask(input logic [1:0] sew);
    return 3'((4'd1 << sew) - 4'd1);
  endfunction

endpackage

// File: rtl/vadd_pipe_unit_if.sv
// Operand/result handshake bundle of vadd_pipe_unit.
//   in side : in_valid, in_ready, vec0, vec1, carry_in, sew, opSel
//   out side: out_valid, out_ready, result, carry_out, sat
// master = the environment (operand fetch + writeback), slave = the unit.
interface vadd_pipe_unit_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int SEW_WIDTH   = 2,
  parameter int OPSEL_WIDTH = 4
);
  localparam int NLANE = DATA_WIDTH / 8;

  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  vec0;
  logic [DATA_WIDTH-1:0]  vec1;
  logic [NLANE-1:0]       carry_in;
  logic [SEW_WIDTH-1:0]   sew;
  logic [OPSEL_WIDTH-1:0] opSel;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  result;
  logic [NLANE-1:0]       carry_out;
  logic                   sat;

  modport master (
    output in_valid, vec0, vec1, carry_in, sew, opSel, out_ready,
    input  in_ready, out_valid, result, carry_out, sat
  );

  modport slave (
    input  in_valid, vec0, vec1, carry_in, sew, opSel, out_ready,
    output in_ready, out_valid, result, carry_out, sat
  );

endinterface

// File: rtl/vadd_elem_slice.sv
// One 64-bit chunk of the segmented adder.
//   op_a, op_b : prepared operands (b already inverted for subtracts)
//   cin        : per-byte carry-in; only bits at element starts are used
//   sew, cls   : element width and decoded op class
//   sum        : element results after saturation clamping
//   cout       : carry (add) / borrow (sub) at each element's first byte, else 0
//   sat        : any element in this chunk clamped
module vadd_elem_slice
  import vadd_pkg::*;
(
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  input  logic [7:0]  cin,
  input  logic [1:0]  sew,
  input  op_class_t   cls,
  output logic [63:0] sum,
  output logic [7:0]  cout,
  output logic        sat
);

  logic [2:0]  mask;
  logic [63:0] raw;
  logic [7:0]  byte_c;
  logic [7:0]  clamp;

  assign mask = lane_mask(sew);

  // Byte-ripple adder: the chain restarts from the lane's own carry-in at
  // every element start, so no carry crosses an element boundary.
  always_comb begin
    logic carry;
    // NOTE: blocking assignments so each byte sees the carry just produced by the byte below it.
    carry  = 1'b0;
    raw    = '0;
    byte_c = '0;
    for (int i = 0; i < 8; i++) begin
      if ((3'(i) & mask) == 3'd0) carry = cin[i];
      {carry, raw[8*i +: 8]} = {1'b0, op_a[8*i +: 8]} + {1'b0, op_b[8*i +: 8]} + 9'(carry);
      byte_c[i] = carry;
    end
  end

  // Each byte looks up the MSB byte (k) of its element to decide the clamp.
  always_comb begin
    logic [2:0] k;
    logic       a_s, b_s, r_s, c_e, ovf;
    logic [7:0] cval;
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    sum   = raw;
    cout  = '0;
    clamp = '0;
    for (int i = 0; i < 8; i++) begin
      k   = 3'(i) | mask;
      a_s = op_a[{k, 3'd7}];
      b_s = op_b[{k, 3'd7}];
      r_s = raw[{k, 3'd7}];
      c_e = byte_c[k];
      if (cls.is_signed) begin
        // op_b is the effective addend, so the plain add overflow rule covers subtract too.
        ovf  = (a_s == b_s) && (r_s != a_s);
        cval = a_s ? ((3'(i) == k) ? 8'h80 : 8'h00) : ((3'(i) == k) ? 8'h7F : 8'hFF);
      end else begin
        ovf  = cls.is_sub ? ~c_e : c_e;
        cval = cls.is_sub ? 8'h00 : 8'hFF;
      end
      clamp[i] = cls.is_sat & ovf;
      if (clamp[i]) sum[8*i +: 8] = cval;
      if ((3'(i) & mask) == 3'd0) cout[i] = cls.is_sub ? ~c_e : c_e;
    end
    sat = |clamp;
  end

endmodule

// File: rtl/vadd_pipe_unit.sv
// Two-stage pipelined lane-packed add/subtract for the vALU.
//   clk, rst  : clock; asynchronous active-low reset
//   bus.slave : in_valid/in_ready + vec0, vec1, carry_in, sew, opSel
//               out_valid/out_ready + result, carry_out, sat
// S1 holds prepared operands (swap/invert applied), per-lane carry-in and op
// class; S2 holds the clamped sums, carry/borrow mask and saturation flag.
module vadd_pipe_unit
  import vadd_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int SEW_WIDTH   = 2,
  parameter int OPSEL_WIDTH = 4
) (
  input logic            clk,
  input logic            rst,
  vadd_pipe_unit_if.slave bus
);

  localparam int NLANE  = DATA_WIDTH / 8;
  localparam int NSLICE = DATA_WIDTH / 64;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_a, s1_b;
  logic [NLANE-1:0]      s1_cin;
  logic [1:0]            s1_sew;
  op_class_t             s1_cls;

  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_result;
  logic [NLANE-1:0]      s2_cout;
  logic                  s2_sat;

  logic                  s2_load, s1_advance, accept;
  op_class_t             in_cls;
  logic [DATA_WIDTH-1:0] prep_a, prep_b, b_src;
  logic [NLANE-1:0]      prep_cin;
  logic [DATA_WIDTH-1:0] sum;
  logic [NLANE-1:0]      cout;
  logic [NSLICE-1:0]     slice_sat;

  // S2 takes a new beat when empty or retiring; S1 drains into it.
  assign s2_load      = !s2_valid || bus.out_ready;
  assign s1_advance   = s1_valid && s2_load;
  assign bus.in_ready = !s1_valid || s1_advance;
  assign accept       = bus.in_valid && bus.in_ready;

  // Subtracts become a + ~b + cin; SBC/MSBC use ~carry_in as that cin.
  // Reserved codes are zeroed so they naturally produce 0/0/0.
  always_comb begin
    in_cls   = decode_op(4'(bus.opSel));
    prep_a   = in_cls.is_rev ? bus.vec1 : bus.vec0;
    b_src    = in_cls.is_rev ? bus.vec0 : bus.vec1;
    prep_b   = in_cls.is_sub ? ~b_src : b_src;
    prep_cin = in_cls.use_cin ? (in_cls.is_sub ? ~bus.carry_in : bus.carry_in)
                              : {NLANE{in_cls.is_sub}};
    if (in_cls.is_nop) begin
      prep_a   = '0;
      prep_b   = '0;
      prep_cin = '0;
    end
  end

  // NOTE: datapath registers are reset as well, so result/carry_out/sat read 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= '0;
      s1_sew   <= '0;
      s1_cls   <= '0;
    end else if (accept) begin
      // NOTE: non-blocking so both stages sample pre-edge values and shift together.
      s1_valid <= 1'b1;
      s1_a     <= prep_a;
      s1_b     <= prep_b;
      s1_cin   <= prep_cin;
      s1_sew   <= 2'(bus.sew);
      s1_cls   <= in_cls;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < NSLICE; g++) begin : g_slice
    vadd_elem_slice u_slice (
      .op_a (s1_a[64*g +: 64]),
      .op_b (s1_b[64*g +: 64]),
      .cin  (s1_cin[8*g +: 8]),
      .sew  (s1_sew),
      .cls  (s1_cls),
      .sum  (sum[64*g +: 64]),
      .cout (cout[8*g +: 8]),
      .sat  (slice_sat[g])
    );
  end

  // S2 only changes on s2_load, which keeps the output frozen while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_cout   <= '0;
      s2_sat    <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= sum;
        s2_cout   <= cout;
        s2_sat    <= |slice_sat;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.result    = s2_result;
  assign bus.carry_out = s2_cout;
  assign bus.sat       = s2_sat;

endmodule

// File: tb/tb_vadd_pipe_unit.sv
// Self-checking bench for vadd_pipe_unit (DATA_WIDTH = 64).
// Directed beats push their expected results, computed by an element-wise
// arithmetic model, onto a scoreboard queue; a monitor pops and compares on
// every retiring beat and also checks in_ready and output hold under stall.
module tb_vadd_pipe_unit;
  import vadd_pkg::*;

  localparam int DW = 64;

  typedef struct packed {
    logic [63:0] res;
    logic [7:0]  co;
    logic        sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vadd_pipe_unit_if #(.DATA_WIDTH(DW), .SEW_WIDTH(2), .OPSEL_WIDTH(4)) bus ();

  vadd_pipe_unit #(.DATA_WIDTH(DW), .SEW_WIDTH(2), .OPSEL_WIDTH(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t       q[$];
  int         n_compared   = 0;
  int         n_mismatched = 0;
  int         n_acc = 0;
  int         n_ret = 0;
  logic       bp_en = 1'b0;
  int         bp_ph = 0;
  logic [3:0] bp_pat = 4'b1001;   // out_ready sequence 1,0,0,1
  logic       held = 1'b0;
  exp_t       held_v;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Element-wise reference using wide signed integer arithmetic.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [7:0] c, input int sw, input int op);
    exp_t x;
    int ebits, ebytes;
    logic signed [67:0] one, emask, hi, lo, ea, eb, ec, sa, sb, r, t;
    logic co, st;
    ebits  = 8 << sw;
    ebytes = 1 << sw;
    x      = '0;
    one    = 68'sd1;
    emask  = (one << ebits) - one;
    hi     = (one << (ebits - 1)) - one;
    lo     = -(one << (ebits - 1));
    for (int e = 0; e < 64 / ebits; e++) begin
      ea = (68'(a) >> (e * ebits)) & emask;
      eb = (68'(b) >> (e * ebits)) & emask;
      ec = 68'(c[e * ebytes]);
      sa = ea[ebits-1] ? ea - (one << ebits) : ea;
      sb = eb[ebits-1] ? eb - (one << ebits) : eb;
      co = 1'b0;
      st = 1'b0;
      case (op)
        0:    begin r = ea + eb; co = r[ebits]; end
        1:    begin r = ea - eb; co = ea < eb; end
        2:    begin r = eb - ea; co = eb < ea; end
        3, 5: begin r = ea + eb + ec; co = r[ebits]; end
        4, 6: begin r = ea - eb - ec; co = ea < (eb + ec); end
        7:    begin r = ea + eb; co = r[ebits]; if (co) begin r = emask; st = 1'b1; end end
        8:    begin
                t = ea + eb; co = t[ebits]; r = sa + sb;
                if (r > hi) begin r = hi; st = 1'b1; end
                else if (r < lo) begin r = lo; st = 1'b1; end
              end
        9:    begin co = ea < eb; r = co ? 68'sd0 : ea - eb; st = co; end
        10:   begin
                co = ea < eb; r = sa - sb;
                if (r > hi) begin r = hi; st = 1'b1; end
                else if (r < lo) begin r = lo; st = 1'b1; end
              end
        default: r = 68'sd0;
      endcase
      x.res = x.res | (64'(r & emask) << (e * ebits));
      x.co[e * ebytes] = co;
      x.sat = x.sat | st;
    end
    return x;
  endfunction

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [7:0] c,
                      input int sw, input int op);
    logic ok;
    int   n;
    bus.vec0     = a;
    bus.vec1     = b;
    bus.carry_in = c;
    bus.sew      = 2'(sw);
    bus.opSel    = 4'(op);
    bus.in_valid = 1'b1;
    q.push_back(model(a, b, c, sw, op));
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_within_budget", 64'(ok), 64'd1);
    if (ok) n_acc++;
    bus.in_valid = 1'b0;
  endtask

  // Call only with the pipe idle and out_ready held 1.
  task automatic check_latency(input string tag);
    @(negedge clk);
    check({tag, "_cycle1_valid"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check({tag, "_cycle2_valid"}, 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue_empty", 64'(q.size()), 64'd0);
  endtask

  // Downstream ready: held 1, or cycling 1,0,0,1 during the backpressure run.
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      bus.out_ready = bp_pat[bp_ph];
      bp_ph = (bp_ph + 1) % 4;
    end else begin
      bus.out_ready = 1'b1;
    end
  end

  // Scoreboard / protocol monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      // With at most one beat in flight S2 is free, so only a full pipe with a stalled output blocks input.
      check("in_ready", 64'(bus.in_ready), 64'(((n_acc - n_ret) < 2) || bus.out_ready));
      if (held) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_result", bus.result, held_v.res);
        check("hold_carry_out", 64'(bus.carry_out), 64'(held_v.co));
        check("hold_sat", 64'(bus.sat), 64'(held_v.sat));
      end
      held = 1'b0;
      if (bus.out_valid === 1'b1) begin
        if (bus.out_ready === 1'b1) begin
          check("output_has_expected", 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("result", bus.result, e.res);
            check("carry_out", 64'(bus.carry_out), 64'(e.co));
            check("sat", 64'(bus.sat), 64'(e.sat));
          end
          n_ret++;
        end else begin
          held   = 1'b1;
          held_v = '{res: bus.result, co: bus.carry_out, sat: bus.sat};
        end
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bp_ops[6];
    bp_ops = '{0, 3, 8, 9, 6, 13};
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.vec0     = '0;
    bus.vec1     = '0;
    bus.carry_in = '0;
    bus.sew      = '0;
    bus.opSel    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_result", bus.result, 64'd0);
    check("reset_carry_out", 64'(bus.carry_out), 64'd0);
    check("reset_sat", 64'(bus.sat), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ADD sew=8: byte 0 wraps with carry, others add 1
    send(64'h00000000_000000FF, 64'h01010101_01010101, 8'h00, 0, OP_ADD);
    check_latency("add_latency");
    // MADC sew=32 with carry-in on both elements
    send(64'hFFFFFFFF_FFFFFFFF, 64'h0, 8'h11, 2, OP_MADC);
    // SADD sew=16 positive and negative overflow, then a clean beat
    send(64'h00000000_80007FFF, 64'h00000000_FFFF0001, 8'h00, 1, OP_SADD);
    send(64'h00000000_00200010, 64'h00000000_00300020, 8'h00, 1, OP_SADD);
    // SSUBU / SUB at sew=64
    send(64'd5, 64'd7, 8'h00, 3, OP_SSUBU);
    send(64'd5, 64'd7, 8'h00, 3, OP_SUB);
    // remaining ops and isolation cases
    send(64'h10203040_50607080, 64'h01FF0140_80017F80, 8'h00, 0, OP_RSUB);
    send(64'h00010000_80000000, 64'h00010001_7FFF0000, 8'hA5, 1, OP_SBC);
    send(64'h00FF0102_00FF0001, 64'h00010001_FF000100, 8'h3C, 0, OP_MSBC);
    send(64'hFFFFFFFF_FFFFFFFF, 64'h0, 8'hFF, 0, OP_ADC);
    send(64'hFFFFFFFF_FFFFFFFF, 64'h0, 8'h01, 3, OP_ADC);
    send(64'h00000000_7FFFFFFF, 64'h80000000_FFFFFFFF, 8'h00, 2, OP_SSUB);
    send(64'hF0F0F0F0_10101010, 64'h20202020_20202020, 8'h00, 0, OP_SADDU);
    send(64'h807F0080_7F00FF01, 64'h01FF7F80_80017F02, 8'h00, 0, OP_SSUB);
    send(64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 1, 12);
    wait_drain();

    // Backpressure: six back-to-back beats under the 1,0,0,1 ready pattern
    bp_en = 1'b1;
    for (int i = 0; i < 6; i++)
      send({$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom),
           int'($urandom_range(0, 3)), bp_ops[i]);
    wait_drain();
    bp_en = 1'b0;
    @(posedge clk);
    #1;

    // Reset with two beats in flight, then a fresh beat
    send(64'h11111111_11111111, 64'h22222222_22222222, 8'h00, 0, OP_ADD);
    send(64'h33333333_33333333, 64'h44444444_44444444, 8'h00, 1, OP_SUB);
    #2;
    rst = 1'b0;
    #1;
    check("inflight_reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("inflight_reset_result", bus.result, 64'd0);
    check("inflight_reset_carry_out", 64'(bus.carry_out), 64'd0);
    check("inflight_reset_sat", 64'(bus.sat), 64'd0);
    q.delete();
    n_acc = n_ret;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    send(64'h00000000_0000FFFF, 64'h00000000_00000001, 8'h00, 1, OP_SADDU);
    check_latency("post_reset_latency");
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
